ie_muldiv_stage: RTL and testbench
==================================

IE_MULDIV_STAGE -- requirements
Module: ie_muldiv_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width.
REQ-002 SHALL have parameter ADDR_W, default 32, PC width.
REQ-003 SHALL have parameter RF_ADDR_W, default 5, register-address width.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 SHALL have port i_clk, input, 1, clock.
REQ-006 SHALL have port i_rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port i_valid, input, 1, ID/EX instruction valid.
REQ-008 SHALL have port i_flush, input, 1, kill the EX instruction.
REQ-009 SHALL have port i_ctrl, input, 8, {branch, jump, jb_sel, mem_we, rf_we, wb_src[2:0]}.
REQ-010 SHALL have port i_alu_ctrl, input, 4, ALU op; i_alu_src, input, 1, 1 selects the immediate.
REQ-011 SHALL have port i_md_en, input, 1, M-extension op; i_md_op, input, 3, funct3.
REQ-012 SHALL have ports i_fwd_0 and i_fwd_1, input, 2 each, forward selects.
REQ-013 SHALL have ports i_rs0_data, i_rs1_data, i_imm, i_m_fwd and i_wb_fwd, input, WIDTH each.
REQ-014 SHALL have ports i_pc and i_pc_plus_4, input, ADDR_W; i_dst, input, RF_ADDR_W.
REQ-015 SHALL have port o_stall, output, 1, hold upstream; o_nxt_pc_src, output, 1; o_nxt_pc, output, ADDR_W.
REQ-016 SHALL have registered EX/MEM outputs: o_im_valid (1), o_im_result, o_im_write_data (WIDTH), o_im_ctrl (5: mem_we, rf_we, wb_src), o_im_nxt_pc, o_im_pc_plus_4 (ADDR_W), o_im_dst (RF_ADDR_W).

Function
REQ-017 SHALL decode each forward select as 00 → register file, 01 → i_m_fwd, 10 → i_wb_fwd, 11 → zero.
REQ-018 SHALL compute o_nxt_pc as i_pc+i_imm when jb_sel=0, and as (forwarded op0 + i_imm) with bit0 cleared when jb_sel=1.
REQ-019 SHALL assert o_nxt_pc_src = i_valid & ~i_flush & ~i_md_en & ((alu_zero & branch) | jump).
REQ-020 SHALL, for a non-M op, register the ALU result and forwarded op1 (write data) into EX/MEM in the same cycle, with o_stall=0.
REQ-021 SHALL run an M-op FSM with states IDLE, BUSY, DONE.
REQ-022 SHALL take IDLE→BUSY when i_valid & i_md_en & ~i_flush, latching operands, with o_stall=1 that cycle.
REQ-023 SHALL hold BUSY for WIDTH cycles, iterating radix-2 shift-add (MUL/MULH/MULHSU/MULHU) or restoring division (DIV/DIVU/REM/REMU), with o_stall=1.
REQ-024 SHALL, in DONE, drive o_stall=0, load the result into EX/MEM, then return to IDLE; total stall is WIDTH+1 cycles.
REQ-025 SHALL fast-path divide-by-zero (quotient all ones, remainder = dividend) and signed MIN/-1 (quotient MIN, remainder 0) via IDLE→DONE, stalling 1 cycle.
REQ-026 SHALL size MUL to the low WIDTH bits and MULH* to the high WIDTH bits of the 2*WIDTH product, with signedness per funct3.
REQ-027 SHALL load a bubble (o_im_valid=0, o_im_ctrl=0) into EX/MEM during every o_stall=1 cycle.
REQ-028 SHALL, on i_flush in any state, abort to IDLE, deassert o_stall the next cycle and load a bubble.
REQ-029 SHALL load a bubble when i_valid=0, and gate o_im_ctrl mem_we/rf_we by o_im_valid.

Reset
REQ-030 SHALL, while i_rst is sampled high, force the FSM to IDLE, clear all EX/MEM registers and iteration counters to 0, and hold o_stall at 0.
REQ-031 SHALL abandon any in-flight M-op on reset and not produce a result for it after reset release.

Configuration
REQ-032 SHALL compile the M unit in only under the macro IE_MULDIV_EN.
REQ-033 SHALL, without IE_MULDIV_EN, remove the FSM, tie o_stall to 0, and execute an i_md_en op in one cycle with result 0.

Structure
REQ-034 SHALL place the i_ctrl field offsets, the ALU ctrl codes, the M funct3 codes and the forward-select codes in a shared package, rv_pkg.
REQ-035 SHALL implement the iterative multiply/divide datapath and FSM as one sub-module, muldiv_unit, with start/done/abort handshake.

Verification
REQ-036 SHALL cover ADD with fwd_0=01, i_m_fwd=5, i_rs1_data=7 → o_im_result=12 one cycle later, o_stall never high.
REQ-037 SHALL cover MULHU 0xFFFFFFFF*0xFFFFFFFF → o_stall high 33 cycles, then o_im_result=0xFFFFFFFE with o_im_valid=1.
REQ-038 SHALL cover DIV 7/0 → 1 stall cycle, quotient 0xFFFFFFFF; REM 0x80000000/-1 → 0.
REQ-039 SHALL cover JALR, jb_sel=1, forwarded op0=0x1001, imm=4 → o_nxt_pc=0x1004, o_nxt_pc_src=1.
REQ-040 SHALL cover i_flush at BUSY cycle 10 of a DIVU → o_stall low next cycle, bubble, no result written.
REQ-041 SHALL cover i_rst asserted mid-MUL → all outputs 0 next cycle, and the next ADD completes normally.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared encodings for the integer execute stage: i_ctrl field offsets,
// ALU operation codes, M-extension funct3 codes, forward selects and the
// multiply/divide FSM states.
package rv_pkg;

  // i_ctrl = {branch, jump, jb_sel, mem_we, rf_we, wb_src[2:0]}
  localparam int CTRL_W         = 8;
  localparam int CTRL_BRANCH    = 7;
  localparam int CTRL_JUMP      = 6;
  localparam int CTRL_JB_SEL    = 5;
  localparam int CTRL_MEM_WE    = 4;
  localparam int CTRL_RF_WE     = 3;
  localparam int CTRL_WB_SRC_HI = 2;
  localparam int CTRL_WB_SRC_LO = 0;
  // EX/MEM keeps only {mem_we, rf_we, wb_src}
  localparam int EXMEM_CTRL_W   = 5;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SLL    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_SLT    = 4'd8,
    ALU_SLTU   = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    FWD_RF   = 2'b00,
    FWD_MEM  = 2'b01,
    FWD_WB   = 2'b10,
    FWD_ZERO = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/ie_muldiv_stage_muldiv_unit.sv
// Iterative M-extension unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, with sign fix-up on the way out.
// Present only when IE_MULDIV_EN is defined.
`ifdef IE_MULDIV_EN
module muldiv_unit
  import rv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_stall,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);

  localparam int               CNT_W   = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  md_state_e          r_state, w_state_nxt;
  md_op_e             r_op;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_div, r_hi, r_lo;
  logic               r_neg, r_fast;
  logic               w_stall;

  logic               w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic               w_is_div, w_div_zero, w_ovf, w_fast, w_neg, w_qbit;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_fast_res;
  logic [WIDTH:0]     w_sum, w_shift, w_diff;
  logic [2*WIDTH-1:0] w_prod, w_prod_s;

  // Operand signedness from funct3.
  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    case (md_op_e'(i_op))
      MD_MULH, MD_DIV, MD_REM: begin
        w_a_signed = 1'b1;
        w_b_signed = 1'b1;
      end
      MD_MULHSU: w_a_signed = 1'b1;
      default: ;
    endcase
  end

  assign w_is_div   = i_op[2];
  assign w_a_neg    = w_a_signed & i_a[WIDTH-1];
  assign w_b_neg    = w_b_signed & i_b[WIDTH-1];
  assign w_a_mag    = w_a_neg ? ('0 - i_a) : i_a;
  assign w_b_mag    = w_b_neg ? ('0 - i_b) : i_b;
  assign w_div_zero = w_is_div & (i_b == '0);
  assign w_ovf      = w_is_div & w_a_signed & (i_a == INT_MIN) & (i_b == '1);
  assign w_fast     = w_div_zero | w_ovf;
  // op[1] distinguishes REM* from DIV* among the divide ops
  assign w_fast_res = w_div_zero ? (i_op[1] ? i_a : '1) : (i_op[1] ? '0 : i_a);
  // Remainder takes the dividend's sign; everything else the XOR of signs
  assign w_neg      = (w_is_div & i_op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

  // One iteration step of each algorithm
  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_div} : '0);
  assign w_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_div};
  assign w_qbit  = ~w_diff[WIDTH];

  assign w_prod   = {r_hi, r_lo};
  assign w_prod_s = r_neg ? ('0 - w_prod) : w_prod;

  // Final result selection with sign correction
  always_comb begin
    o_result = r_lo;
    if (!r_fast) begin
      case (r_op)
        MD_MUL:                       o_result = r_lo;
        MD_MULH, MD_MULHSU, MD_MULHU: o_result = w_prod_s[2*WIDTH-1:WIDTH];
        MD_DIV, MD_DIVU:              o_result = r_neg ? ('0 - r_lo) : r_lo;
        default:                      o_result = r_neg ? ('0 - r_hi) : r_hi;
      endcase
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      MD_IDLE: begin
        if (i_start && !i_abort) begin
          w_stall     = 1'b1;
          w_state_nxt = w_fast ? MD_DONE : MD_BUSY;
        end
      end
      MD_BUSY: begin
        w_stall = 1'b1;
        if (i_abort)              w_state_nxt = MD_IDLE;
        else if (r_cnt == LAST)   w_state_nxt = MD_DONE;
      end
      MD_DONE: begin
        o_done      = ~i_abort;
        w_state_nxt = MD_IDLE;
      end
      default: w_state_nxt = MD_IDLE;
    endcase
  end

  assign o_stall = w_stall & ~i_rst;

  // State register plus operand latch and iteration datapath
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= MD_IDLE;
      r_op    <= MD_MUL;
      r_cnt   <= '0;
      r_div   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_neg   <= 1'b0;
      r_fast  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        MD_IDLE: begin
          if (i_start && !i_abort) begin
            r_op   <= md_op_e'(i_op);
            r_neg  <= w_neg;
            r_fast <= w_fast;
            r_cnt  <= '0;
            r_hi   <= '0;
            if (w_fast) begin
              r_div <= '0;
              r_lo  <= w_fast_res;
            end else if (w_is_div) begin
              r_div <= w_b_mag;
              r_lo  <= w_a_mag;
            end else begin
              r_div <= w_a_mag;
              r_lo  <= w_b_mag;
            end
          end
        end
        MD_BUSY: begin
          if (!i_abort) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_op[2]) begin
              r_hi <= w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
              r_lo <= {r_lo[WIDTH-2:0], w_qbit};
            end else begin
              r_hi <= w_sum[WIDTH:1];
              r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`endif

// File: rtl/ie_muldiv_stage.sv
// Integer execute stage: operand forwarding, ALU, branch/jump target and
// the EX/MEM pipeline register. The iterative multiply/divide unit is
// included when IE_MULDIV_EN is defined; otherwise M ops complete in one
// cycle with result 0 and the stage never stalls.
module ie_muldiv_stage
  import rv_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ADDR_W    = 32,
  parameter int RF_ADDR_W = 5
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  input  logic                    i_flush,
  input  logic [CTRL_W-1:0]       i_ctrl,
  input  logic [3:0]              i_alu_ctrl,
  input  logic                    i_alu_src,
  input  logic                    i_md_en,
  input  logic [2:0]              i_md_op,
  input  logic [1:0]              i_fwd_0,
  input  logic [1:0]              i_fwd_1,
  input  logic [WIDTH-1:0]        i_rs0_data,
  input  logic [WIDTH-1:0]        i_rs1_data,
  input  logic [WIDTH-1:0]        i_imm,
  input  logic [WIDTH-1:0]        i_m_fwd,
  input  logic [WIDTH-1:0]        i_wb_fwd,
  input  logic [ADDR_W-1:0]       i_pc,
  input  logic [ADDR_W-1:0]       i_pc_plus_4,
  input  logic [RF_ADDR_W-1:0]    i_dst,
  output logic                    o_stall,
  output logic                    o_nxt_pc_src,
  output logic [ADDR_W-1:0]       o_nxt_pc,
  output logic                    o_im_valid,
  output logic [WIDTH-1:0]        o_im_result,
  output logic [WIDTH-1:0]        o_im_write_data,
  output logic [EXMEM_CTRL_W-1:0] o_im_ctrl,
  output logic [ADDR_W-1:0]       o_im_nxt_pc,
  output logic [ADDR_W-1:0]       o_im_pc_plus_4,
  output logic [RF_ADDR_W-1:0]    o_im_dst
);

  localparam int SHAMT_W = $clog2(WIDTH);

  logic [WIDTH-1:0]   w_op0, w_op1, w_alu_b, w_alu_res, w_md_result, w_result;
  logic [SHAMT_W-1:0] w_shamt;
  logic [ADDR_W-1:0]  w_jb_sum;
  logic               w_alu_zero, w_stall, w_md_done, w_load;

  // Forwarding muxes for both source operands
  always_comb begin
    w_op0 = '0;
    w_op1 = '0;
    case (fwd_sel_e'(i_fwd_0))
      FWD_RF:  w_op0 = i_rs0_data;
      FWD_MEM: w_op0 = i_m_fwd;
      FWD_WB:  w_op0 = i_wb_fwd;
      default: w_op0 = '0;
    endcase
    case (fwd_sel_e'(i_fwd_1))
      FWD_RF:  w_op1 = i_rs1_data;
      FWD_MEM: w_op1 = i_m_fwd;
      FWD_WB:  w_op1 = i_wb_fwd;
      default: w_op1 = '0;
    endcase
  end

  assign w_alu_b = i_alu_src ? i_imm : w_op1;
  assign w_shamt = w_alu_b[SHAMT_W-1:0];

  // Single-cycle ALU
  always_comb begin
    w_alu_res = '0;
    case (alu_op_e'(i_alu_ctrl))
      ALU_ADD:    w_alu_res = w_op0 + w_alu_b;
      ALU_SUB:    w_alu_res = w_op0 - w_alu_b;
      ALU_AND:    w_alu_res = w_op0 & w_alu_b;
      ALU_OR:     w_alu_res = w_op0 | w_alu_b;
      ALU_XOR:    w_alu_res = w_op0 ^ w_alu_b;
      ALU_SLL:    w_alu_res = w_op0 << w_shamt;
      ALU_SRL:    w_alu_res = w_op0 >> w_shamt;
      ALU_SRA:    w_alu_res = WIDTH'($signed(w_op0) >>> w_shamt);
      ALU_SLT:    w_alu_res = WIDTH'($signed(w_op0) < $signed(w_alu_b));
      ALU_SLTU:   w_alu_res = WIDTH'(w_op0 < w_alu_b);
      ALU_PASS_B: w_alu_res = w_alu_b;
      default:    w_alu_res = '0;
    endcase
  end

  assign w_alu_zero = (w_alu_res == '0);

  // Jump/branch target: PC-relative, or register-relative with bit 0 cleared
  assign w_jb_sum     = ADDR_W'(w_op0) + ADDR_W'(i_imm);
  assign o_nxt_pc     = i_ctrl[CTRL_JB_SEL] ? {w_jb_sum[ADDR_W-1:1], 1'b0}
                                            : i_pc + ADDR_W'(i_imm);
  assign o_nxt_pc_src = i_valid & ~i_flush & ~i_md_en &
                        ((w_alu_zero & i_ctrl[CTRL_BRANCH]) | i_ctrl[CTRL_JUMP]);

`ifdef IE_MULDIV_EN
  muldiv_unit #(.WIDTH(WIDTH)) u_muldiv (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (i_valid & i_md_en),
    .i_abort  (i_flush),
    .i_op     (i_md_op),
    .i_a      (w_op0),
    .i_b      (w_op1),
    .o_stall  (w_stall),
    .o_done   (w_md_done),
    .o_result (w_md_result)
  );
`else
  logic w_unused_md;
  assign w_unused_md = ^i_md_op;
  assign w_stall     = 1'b0;
  assign w_md_done   = 1'b1;
  assign w_md_result = '0;
`endif

  assign o_stall  = w_stall;
  assign w_result = i_md_en ? w_md_result : w_alu_res;
  // An M op only retires once the unit reports done; stalls and flushes leave a bubble
  assign w_load   = i_valid & ~i_flush & ~w_stall & (~i_md_en | w_md_done);

  // EX/MEM pipeline register; a bubble clears every field
  always_ff @(posedge i_clk) begin
    if (i_rst || !w_load) begin
      o_im_valid      <= 1'b0;
      o_im_result     <= '0;
      o_im_write_data <= '0;
      o_im_ctrl       <= '0;
      o_im_nxt_pc     <= '0;
      o_im_pc_plus_4  <= '0;
      o_im_dst        <= '0;
    end else begin
      o_im_valid      <= 1'b1;
      o_im_result     <= w_result;
      o_im_write_data <= w_op1;
      o_im_ctrl       <= i_ctrl[EXMEM_CTRL_W-1:0];
      o_im_nxt_pc     <= o_nxt_pc;
      o_im_pc_plus_4  <= i_pc_plus_4;
      o_im_dst        <= i_dst;
    end
  end

endmodule

// File: tb/tb_ie_muldiv_stage.sv
// Self-checking bench for ie_muldiv_stage: directed cases plus randomized
// instructions compared against an arithmetic reference model. Expected
// stall lengths and M results follow whether IE_MULDIV_EN is defined.
module tb_ie_muldiv_stage;

  logic        i_clk = 1'b0;
  logic        i_rst, i_valid, i_flush, i_alu_src, i_md_en;
  logic [7:0]  i_ctrl;
  logic [3:0]  i_alu_ctrl;
  logic [2:0]  i_md_op;
  logic [1:0]  i_fwd_0, i_fwd_1;
  logic [31:0] i_rs0_data, i_rs1_data, i_imm, i_m_fwd, i_wb_fwd, i_pc, i_pc_plus_4;
  logic [4:0]  i_dst;
  logic        o_stall, o_nxt_pc_src, o_im_valid;
  logic [31:0] o_nxt_pc, o_im_result, o_im_write_data, o_im_nxt_pc, o_im_pc_plus_4;
  logic [4:0]  o_im_ctrl, o_im_dst;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 i_clk = ~i_clk;

  ie_muldiv_stage #(.WIDTH(32), .ADDR_W(32), .RF_ADDR_W(5)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_flush(i_flush),
    .i_ctrl(i_ctrl), .i_alu_ctrl(i_alu_ctrl), .i_alu_src(i_alu_src),
    .i_md_en(i_md_en), .i_md_op(i_md_op), .i_fwd_0(i_fwd_0), .i_fwd_1(i_fwd_1),
    .i_rs0_data(i_rs0_data), .i_rs1_data(i_rs1_data), .i_imm(i_imm),
    .i_m_fwd(i_m_fwd), .i_wb_fwd(i_wb_fwd), .i_pc(i_pc), .i_pc_plus_4(i_pc_plus_4),
    .i_dst(i_dst), .o_stall(o_stall), .o_nxt_pc_src(o_nxt_pc_src), .o_nxt_pc(o_nxt_pc),
    .o_im_valid(o_im_valid), .o_im_result(o_im_result), .o_im_write_data(o_im_write_data),
    .o_im_ctrl(o_im_ctrl), .o_im_nxt_pc(o_im_nxt_pc), .o_im_pc_plus_4(o_im_pc_plus_4),
    .o_im_dst(o_im_dst)
  );

  typedef struct {
    logic [7:0]  ctrl;
    logic [3:0]  alu;
    logic        alu_src;
    logic        md_en;
    logic [2:0]  md_op;
    logic [1:0]  f0, f1;
    logic [31:0] rs0, rs1, imm, mfwd, wbfwd, pc;
    logic [4:0]  dst;
  } instr_t;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] fwd(input logic [1:0] s, input logic [31:0] rf, m, wb);
    case (s)
      2'd0:    return rf;
      2'd1:    return m;
      2'd2:    return wb;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, b);
    int sa, sb;
    sa = a; sb = b;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << (b % 32);
      4'd6:  return a >> (b % 32);
      4'd7:  return 32'(sa >>> (b % 32));
      4'd8:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] md_ref(input logic [2:0] op, input logic [31:0] a, b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
`ifdef IE_MULDIV_EN
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'({32'd0, a});  ub = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = ua * ub; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
`else
    return 32'd0;
`endif
  endfunction

  function automatic int exp_stall(input instr_t t, input logic [31:0] a, b);
`ifdef IE_MULDIV_EN
    if (!t.md_en) return 0;
    if (t.md_op[2] && (b == 0 || (!t.md_op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return 33;
`else
    return 0;
`endif
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_idle();
    i_valid = 0; i_flush = 0; i_ctrl = 0; i_alu_ctrl = 0; i_alu_src = 0;
    i_md_en = 0; i_md_op = 0; i_fwd_0 = 0; i_fwd_1 = 0;
    i_rs0_data = 0; i_rs1_data = 0; i_imm = 0; i_m_fwd = 0; i_wb_fwd = 0;
    i_pc = 0; i_pc_plus_4 = 0; i_dst = 0;
  endtask

  task automatic drive(input instr_t t);
    i_valid = 1; i_flush = 0; i_ctrl = t.ctrl; i_alu_ctrl = t.alu; i_alu_src = t.alu_src;
    i_md_en = t.md_en; i_md_op = t.md_op; i_fwd_0 = t.f0; i_fwd_1 = t.f1;
    i_rs0_data = t.rs0; i_rs1_data = t.rs1; i_imm = t.imm; i_m_fwd = t.mfwd;
    i_wb_fwd = t.wbfwd; i_pc = t.pc; i_pc_plus_4 = t.pc + 32'd4; i_dst = t.dst;
  endtask

  function automatic instr_t blank();
    instr_t t;
    t = '{ctrl: 0, alu: 0, alu_src: 0, md_en: 0, md_op: 0, f0: 0, f1: 0,
          rs0: 0, rs1: 0, imm: 0, mfwd: 0, wbfwd: 0, pc: 32'h100, dst: 5'd1};
    return t;
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // Issue one instruction, wait out any stall, then check the EX/MEM contents
  task automatic exec(input instr_t t, input string tag);
    logic [31:0] a, b, res, npc, jb;
    logic        src;
    int          n, es;
    a   = fwd(t.f0, t.rs0, t.mfwd, t.wbfwd);
    b   = fwd(t.f1, t.rs1, t.mfwd, t.wbfwd);
    res = t.md_en ? md_ref(t.md_op, a, b) : alu_ref(t.alu, a, t.alu_src ? t.imm : b);
    jb  = a + t.imm;
    npc = t.ctrl[5] ? {jb[31:1], 1'b0} : t.pc + t.imm;
    src = !t.md_en && ((t.ctrl[7] && alu_ref(t.alu, a, t.alu_src ? t.imm : b) == 0) || t.ctrl[6]);
    es  = exp_stall(t, a, b);

    drive(t);
    #1;
    check({tag, ".nxt_pc"}, o_nxt_pc, npc);
    check({tag, ".nxt_pc_src"}, o_nxt_pc_src, src);
    n = 0;
    while (o_stall && n < 100) begin
      n++;
      @(posedge i_clk); #1;
    end
    check({tag, ".stall_cycles"}, n, es);
    @(posedge i_clk); #1;
    check({tag, ".valid"}, o_im_valid, 1);
    check({tag, ".result"}, o_im_result, res);
    check({tag, ".wdata"}, o_im_write_data, b);
    check({tag, ".ctrl_dst"}, {o_im_ctrl, o_im_dst}, {t.ctrl[4:0], t.dst});
    check({tag, ".pcs"}, {o_im_nxt_pc, o_im_pc_plus_4}, {npc, t.pc + 32'd4});
    i_valid = 0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".valid"}, o_im_valid, 0);
    check({tag, ".result_wdata"}, {o_im_result, o_im_write_data}, 0);
    check({tag, ".ctrl_dst"}, {o_im_ctrl, o_im_dst}, 0);
    check({tag, ".pcs"}, {o_im_nxt_pc, o_im_pc_plus_4}, 0);
    check({tag, ".stall"}, o_stall, 0);
  endtask

  // Counts EX/MEM loads over a window where nothing may retire
  task automatic quiet_window(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge i_clk); #1;
      if (o_im_valid || o_stall) seen++;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t t;
    set_idle();
    i_rst = 1;
    repeat (3) @(posedge i_clk);
    #1;
    check_cleared("reset");
    check("reset.nxt_pc_src", o_nxt_pc_src, 0);
    i_rst = 0;

    // ADD with op0 forwarded from MEM: 5 + 7
    t = blank(); t.ctrl = 8'b0000_1001; t.alu = 4'd0; t.f0 = 2'b01; t.mfwd = 32'd5; t.rs1 = 32'd7;
    exec(t, "add_fwd");
    check("add_fwd.is_12", o_im_result, 32'd12);

    // JALR: target from forwarded op0, low bit cleared
    t = blank(); t.ctrl = 8'b0111_1010; t.f0 = 2'b10; t.wbfwd = 32'h1001; t.imm = 32'd4; t.pc = 32'h2000;
    exec(t, "jalr");
    check("jalr.target", o_im_nxt_pc, 32'h1004);

    // Taken branch: SUB of equal operands, PC-relative target
    t = blank(); t.ctrl = 8'b1000_0000; t.alu = 4'd1; t.rs0 = 32'h55; t.rs1 = 32'h55; t.imm = 32'hFFFF_FFF0;
    exec(t, "beq");

    // M ops: long multiply and the divide fast paths
    t = blank(); t.ctrl = 8'b0000_1000; t.md_en = 1; t.md_op = 3'd3;
    t.rs0 = 32'hFFFF_FFFF; t.rs1 = 32'hFFFF_FFFF;
    exec(t, "mulhu");
    t = blank(); t.ctrl = 8'b0000_1000; t.md_en = 1; t.md_op = 3'd4; t.rs0 = 32'd7; t.rs1 = 32'd0;
    exec(t, "div_by_zero");
    t = blank(); t.ctrl = 8'b0000_1000; t.md_en = 1; t.md_op = 3'd6;
    t.rs0 = 32'h8000_0000; t.rs1 = 32'hFFFF_FFFF;
    exec(t, "rem_ovf");
    t = blank(); t.ctrl = 8'b0000_1000; t.md_en = 1; t.md_op = 3'd4;
    t.rs0 = 32'hFFFF_FF9C; t.rs1 = 32'd7;
    exec(t, "div_neg");

    // Flush a DIVU in its tenth BUSY cycle
    t = blank(); t.ctrl = 8'b0000_1000; t.md_en = 1; t.md_op = 3'd5; t.rs0 = 32'd1000; t.rs1 = 32'd3;
    drive(t);
`ifdef IE_MULDIV_EN
    for (int k = 0; k < 10; k++) begin
      @(posedge i_clk); #1;
    end
`endif
    i_flush = 1;
    #1;
    @(posedge i_clk); #1;
    check("flush.stall_next", o_stall, 0);
    check("flush.bubble", {o_im_valid, o_im_ctrl}, 0);
    set_idle();
    quiet_window("flush.no_result", 40);

    // Reset in the middle of a MUL
    t = blank(); t.ctrl = 8'b0000_1000; t.md_en = 1; t.md_op = 3'd0;
    t.rs0 = 32'h1234_5678; t.rs1 = 32'h9ABC_DEF0;
    drive(t);
    repeat (6) @(posedge i_clk);
    #1;
    set_idle();
    i_rst = 1;
    #1;
    check("rst_mid.stall_held_low", o_stall, 0);
    @(posedge i_clk); #1;
    check_cleared("rst_mid");
    check("rst_mid.nxt_pc", {o_nxt_pc, o_nxt_pc_src}, 0);
    @(posedge i_clk); #1;
    i_rst = 0;
    quiet_window("rst_mid.abandoned", 40);
    t = blank(); t.ctrl = 8'b0000_1001; t.alu = 4'd0; t.rs0 = 32'd100; t.rs1 = 32'd23;
    exec(t, "add_after_rst");

    // Randomized mix of ALU and M instructions
    for (int i = 0; i < 80; i++) begin
      t.ctrl    = 8'($urandom);
      t.alu     = 4'($urandom_range(0, 10));
      t.alu_src = 1'($urandom);
      t.md_en   = ($urandom_range(0, 2) == 0);
      t.md_op   = 3'($urandom);
      t.f0      = 2'($urandom);
      t.f1      = 2'($urandom);
      t.rs0     = rand_word();
      t.rs1     = rand_word();
      t.imm     = rand_word();
      t.mfwd    = rand_word();
      t.wbfwd   = rand_word();
      t.pc      = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      t.dst     = 5'($urandom);
      exec(t, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
